// File: rtl/aes_pkg.sv
// AES round primitives: mode encodings, the stage record, GF(2^8) helpers,
// the S-box and the SubBytes/ShiftRows state transforms.
package aes_pkg;

  localparam logic [1:0] MODE_FULL = 2'b00;
  localparam logic [1:0] MODE_LAST = 2'b01;
  localparam logic [1:0] MODE_KEY  = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef struct packed {
    logic [1:0]   mode;
    logic [127:0] key;
    logic [127:0] data;
  } stage_t;

  // State byte (row r, column c); byte 0 sits in bits [127:120].
  function automatic int bidx(input int r, input int c);
    return r + 4 * c;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as b^254, then the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*bidx(r, c) -: 8] = s[127-8*bidx(r, (c + r) % 4) -: 8];
    return o;
  endfunction

endpackage

// File: rtl/aes_mix_columns.sv
// Combinational AES MixColumns over the full 128-bit state.
module aes_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] i_data,
  output logic [127:0] o_data
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = i_data[127-8*bidx(0, c) -: 8];
    assign w_a1 = i_data[127-8*bidx(1, c) -: 8];
    assign w_a2 = i_data[127-8*bidx(2, c) -: 8];
    assign w_a3 = i_data[127-8*bidx(3, c) -: 8];

    assign o_data[127-8*bidx(0, c) -: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    assign o_data[127-8*bidx(1, c) -: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
    assign o_data[127-8*bidx(2, c) -: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
    assign o_data[127-8*bidx(3, c) -: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
  end

endmodule

// File: rtl/aes_round_pipe.sv
// Pipelined single AES encryption round (1..3 register stages, global stall).
// AES_ROUND_KEYONLY_EN adds mode 10 = data ^ key; otherwise mode 10 is a full round.
module aes_round_pipe
  import aes_pkg::*;
#(
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [127:0]     in_data,
  input  logic [127:0]     in_key,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag
);

  logic [PIPE_STAGES:1] r_vld_pipe;
  stage_t               r_stg [1:PIPE_STAGES];
  logic [TAG_W-1:0]     r_tag [1:PIPE_STAGES];

  logic [127:0] w_nxt [1:PIPE_STAGES];
  logic [127:0] w_a, w_mc_in, w_mc_out, w_b, w_ark_in, w_ark_key, w_ark;
  logic [1:0]   w_mc_mode;
  logic         w_adv;

  function automatic logic use_mc(input logic [1:0] m);
    case (m)
      MODE_LAST:                     return 1'b0;
`ifdef AES_ROUND_KEYONLY_EN
      MODE_KEY:                      return 1'b0;
      MODE_FULL, MODE_RSVD:          return 1'b1;
`else
      MODE_FULL, MODE_KEY, MODE_RSVD: return 1'b1;
`endif
      default:                       return 1'b1;
    endcase
  endfunction

  // Single advance enable: a stalled output freezes every stage at once.
  assign w_adv     = !r_vld_pipe[PIPE_STAGES] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld_pipe[PIPE_STAGES];
  assign out_data  = r_stg[PIPE_STAGES].data;
  assign out_tag   = r_tag[PIPE_STAGES];

`ifdef AES_ROUND_KEYONLY_EN
  assign w_a = (in_mode == MODE_KEY) ? in_data : shift_rows(sub_bytes(in_data));
`else
  assign w_a = shift_rows(sub_bytes(in_data));
`endif

  aes_mix_columns u_mc (
    .i_data (w_mc_in),
    .o_data (w_mc_out)
  );

  assign w_b   = use_mc(w_mc_mode) ? w_mc_out : w_mc_in;
  assign w_ark = w_ark_in ^ w_ark_key;

  // Where each operation lands depends on the pipeline depth.
  if (PIPE_STAGES == 1) begin : g_s1
    assign w_mc_in   = w_a;
    assign w_mc_mode = in_mode;
    assign w_ark_in  = w_b;
    assign w_ark_key = in_key;
    assign w_nxt[1]  = w_ark;
  end else if (PIPE_STAGES == 2) begin : g_s2
    assign w_mc_in   = r_stg[1].data;
    assign w_mc_mode = r_stg[1].mode;
    assign w_ark_in  = w_b;
    assign w_ark_key = r_stg[1].key;
    assign w_nxt[1]  = w_a;
    assign w_nxt[2]  = w_ark;
  end else begin : g_s3
    assign w_mc_in   = r_stg[1].data;
    assign w_mc_mode = r_stg[1].mode;
    assign w_ark_in  = r_stg[2].data;
    assign w_ark_key = r_stg[2].key;
    assign w_nxt[1]  = w_a;
    assign w_nxt[2]  = w_b;
    assign w_nxt[3]  = w_ark;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      for (int s = 1; s <= PIPE_STAGES; s++) begin
        r_stg[s] <= '0;
        r_tag[s] <= '0;
      end
    end else if (w_adv) begin
      r_vld_pipe[1] <= in_valid;
      r_stg[1]      <= '{mode: in_mode, key: in_key, data: w_nxt[1]};
      r_tag[1]      <= in_tag;
      for (int s = 2; s <= PIPE_STAGES; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_stg[s]      <= '{mode: r_stg[s-1].mode, key: r_stg[s-1].key, data: w_nxt[s]};
        r_tag[s]      <= r_tag[s-1];
      end
    end
  end

endmodule

// File: tb/tb_aes_round_pipe.sv
// Scoreboard bench: one DUT per depth (1, 2, 3) driven by random and FIPS-197 stimulus.
module tb_aes_round_pipe;

  localparam int TW = 4;

  typedef struct {
    logic [127:0]  d;
    logic [TW-1:0] t;
    int            acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [7:0] sbt [256];

  // S-box built from generator-3 log walk plus affine map.
  initial begin
    logic [7:0] sp, sq, sx;
    sp = 8'h01;
    sq = 8'h01;
    do begin
      sp = sp ^ {sp[6:0], 1'b0} ^ (sp[7] ? 8'h1b : 8'h00);
      sq = sq ^ {sq[6:0], 1'b0};
      sq = sq ^ {sq[5:0], 2'b0};
      sq = sq ^ {sq[3:0], 4'b0};
      if (sq[7]) sq = sq ^ 8'h09;
      sx = sq ^ {sq[6:0], sq[7]} ^ {sq[5:0], sq[7:6]} ^ {sq[4:0], sq[7:5]} ^ {sq[3:0], sq[7:4]};
      sbt[sp] = sx ^ 8'h63;
    end while (sp != 8'h01);
    sbt[0] = 8'h63;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] d, input logic [127:0] k,
                                             input logic [1:0] m);
    logic [7:0] st [4][4];
    logic [7:0] sh [4][4];
    logic [7:0] mx [4][4];
    logic [7:0] cf [4];
    logic [127:0] o;
    cf = '{8'd2, 8'd3, 8'd1, 8'd1};
`ifdef AES_ROUND_KEYONLY_EN
    if (m == 2'b10) return d ^ k;
`endif
    for (int i = 0; i < 16; i++) st[i % 4][i / 4] = sbt[d[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) sh[r][c] = st[r][(c + r) % 4];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (m == 2'b01) mx[r][c] = sh[r][c];
        else begin
          mx[r][c] = 8'h00;
          for (int j = 0; j < 4; j++) mx[r][c] = mx[r][c] ^ gf_mul(cf[(j - r + 4) % 4], sh[j][c]);
        end
      end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = mx[i % 4][i / 4];
    return o ^ k;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar gi = 1; gi <= 3; gi++) begin : g_ps
    localparam int PS = gi;

    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_mode = '0;
    logic [127:0]     in_data = '0;
    logic [127:0]     in_key = '0;
    logic [TW-1:0]    in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [127:0]     out_data;
    logic [TW-1:0]    out_tag;

    exp_t q[$];
    int   rmode = 0;
    int   rc = 0;
    int   last_low = -1;
    int   n_out = 0;
    bit   hold = 1'b0;
    logic [127:0]  hold_d;
    logic [TW-1:0] hold_t;
    bit   done = 1'b0;

    aes_round_pipe #(.PIPE_STAGES(PS), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .in_data(in_data), .in_key(in_key), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
    );

    function automatic string nm(input string s);
      return $sformatf("ps%0d_%s", PS, s);
    endfunction

    // Consumer: always ready, random backpressure, or low on stream cycles 3..5.
    initial forever begin
      @(negedge clk);
      rc++;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = !(rc >= 3 && rc <= 5);
      endcase
    end

    // Monitor: pops the scoreboard on every consumed output.
    initial forever begin
      exp_t e;
      int   lat;
      @(negedge clk);
      #2;
      if (rst) hold = 1'b0;
      else begin
        if (!out_ready) last_low = cyc;
        if (hold) begin
          chk(nm("hold_valid"), 128'(out_valid), 128'd1);
          chk(nm("hold_data"), out_data, hold_d);
          chk(nm("hold_tag"), 128'(out_tag), 128'(hold_t));
        end
        if (out_valid && out_ready) begin
          n_out++;
          if (q.size() == 0) chk(nm("stray_output"), 128'(q.size()), 128'd1);
          else begin
            e = q.pop_front();
            chk(nm("data"), out_data, e.d);
            chk(nm("tag"), 128'(out_tag), 128'(e.t));
            lat = cyc - e.acc;
            if (last_low <= e.acc) chk(nm("latency"), 128'(lat), 128'(PS));
            else chk(nm("latency_min"), 128'(lat >= PS), 128'd1);
          end
        end
        hold   = out_valid && !out_ready;
        hold_d = out_data;
        hold_t = out_tag;
      end
    end

    task automatic send(input logic [1:0] m, input logic [127:0] d, input logic [127:0] k,
                        input logic [TW-1:0] t, input logic [127:0] ex);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_mode  = m;
      in_data  = d;
      in_key   = k;
      in_tag   = t;
      #1;
      while (!in_ready && n < 64) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (!in_ready) chk(nm("accept_timeout"), 128'(in_ready), 128'd1);
      else begin
        e.d   = ex;
        e.t   = t;
        e.acc = cyc;
        q.push_back(e);
      end
    endtask

    task automatic idle(input int n);
      repeat (n) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    endtask

    task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 300) begin
        @(negedge clk);
        in_valid = 1'b0;
        n++;
      end
      chk(nm("drain_left"), 128'(q.size()), 128'd0);
    endtask

    initial begin
      logic [127:0]  d, k, ex;
      logic [1:0]    m;
      int            nb;
      repeat (3) @(negedge clk);
      #1;
      chk(nm("rst_out_valid"), 128'(out_valid), 128'd0);
      chk(nm("rst_in_ready"), 128'(in_ready), 128'd1);
      chk(nm("rst_out_data"), out_data, 128'd0);
      chk(nm("rst_out_tag"), 128'(out_tag), 128'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk(nm("post_rst_in_ready"), 128'(in_ready), 128'd1);

      send(2'b00, 128'h00102030405060708090a0b0c0d0e0f0, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
           4'd1, 128'h89d810e8855ace682d1843d8cb128fe4);
      send(2'b01, 128'hbd6e7c3df2b5779e0b61216e8b10b689, 128'h13111d7fe3944a17f307a78b4d2b30c5,
           4'd2, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      d = 128'h00112233445566778899aabbccddeeff;
      k = 128'h000102030405060708090a0b0c0d0e0f;
`ifdef AES_ROUND_KEYONLY_EN
      ex = 128'h00102030405060708090a0b0c0d0e0f0;
`else
      ex = ref_round(d, k, 2'b00);
`endif
      send(2'b10, d, k, 4'd3, ex);
      drain();

      // 8-block stream with a 3-cycle consumer stall.
      rmode = 2;
      rc    = 0;
      for (int t = 0; t < 8; t++) begin
        d = rnd128();
        k = rnd128();
        m = 2'($urandom_range(0, 3));
        send(m, d, k, 4'(t), ref_round(d, k, m));
      end
      drain();
      rmode = 0;

      rmode = 1;
      repeat (150) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        d = rnd128();
        k = rnd128();
        m = 2'($urandom_range(0, 3));
        send(m, d, k, 4'($urandom_range(0, 15)), ref_round(d, k, m));
      end
      rmode = 0;
      drain();

      // Reset with two blocks in flight.
      for (int i = 0; i < 2; i++) begin
        d = rnd128();
        k = rnd128();
        send(2'b00, d, k, 4'(8 + i), ref_round(d, k, 2'b00));
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      q.delete();
      #1;
      chk(nm("midrst_out_valid"), 128'(out_valid), 128'd0);
      chk(nm("midrst_in_ready"), 128'(in_ready), 128'd1);
      chk(nm("midrst_out_data"), out_data, 128'd0);
      chk(nm("midrst_out_tag"), 128'(out_tag), 128'd0);
      nb = n_out;
      idle(2);
      @(negedge clk);
      rst = 1'b0;
      idle(10);
      chk(nm("stale_outputs"), 128'(n_out - nb), 128'd0);
      done = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(g_ps[1].done && g_ps[2].done && g_ps[3].done) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    chk("all_depths_done", 128'({g_ps[1].done, g_ps[2].done, g_ps[3].done}), 128'd7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_round_pipe.md
AES_ROUND_PIPE -- requirements
Module: aes_round_pipe

Interface
REQ-001 SHALL have parameter PIPE_STAGES, default 2, meaning the number of register stages from input acceptance to output valid; legal values 1, 2, 3.
REQ-002 SHALL have parameter TAG_W, default 4, meaning the width of the sideband tag carried alongside each block.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  input block present.
REQ-007 in_ready  output  1  block accepted when in_valid && in_ready.
REQ-008 in_mode  input  2  round type: 00 full round, 01 last round, 10 key-only, 11 reserved.
REQ-009 in_data  input  128  state; byte 0 = in_data[127:120], column-major per FIPS-197.
REQ-010 in_key  input  128  round key for this block.
REQ-011 in_tag  input  TAG_W  sideband tag, passed through unchanged.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-014 out_data  output  128  round result, same byte order as in_data.
REQ-015 out_tag  output  TAG_W  tag of the block on out_data.

Function
REQ-016 Full round SHALL compute AddRoundKey(MixColumns(ShiftRows(SubBytes(in_data))), in_key).
REQ-017 Last round SHALL compute AddRoundKey(ShiftRows(SubBytes(in_data)), in_key), with no MixColumns.
REQ-018 Mode 11 SHALL behave as a full round.
REQ-019 The pipeline SHALL use one global advance enable, adv = !out_valid || out_ready; in_ready SHALL equal adv.
REQ-020 When adv=1, every stage SHALL shift one position, including valid bits, so bubbles propagate.
REQ-021 When adv=0, every stage SHALL hold data, key, mode, tag and valid.
REQ-022 Latency from acceptance to out_valid SHALL be exactly PIPE_STAGES cycles when out_ready stays high.
REQ-023 Throughput SHALL be one block per cycle when out_ready stays high.
REQ-024 Stage split, by PIPE_STAGES:
  - 3: SubBytes+ShiftRows | MixColumns | AddRoundKey.
  - 2: SubBytes+ShiftRows | MixColumns+AddRoundKey.
  - 1: all operations before a single register.
REQ-025 Key, mode and tag SHALL travel through the pipeline with their data block.
REQ-026 Simultaneous input accept and output consume SHALL be lossless: no block is dropped or duplicated.
REQ-027 out_data and out_tag SHALL remain stable while out_valid=1 and out_ready=0.
REQ-028 in_ready SHALL have no combinational path from in_valid.

Reset
REQ-029 While rst=1, all stage valid bits, out_valid, out_data and out_tag SHALL be 0.
REQ-030 in_ready SHALL read 1 during reset and after reset release.
REQ-031 Blocks in flight when rst asserts SHALL be discarded; no output SHALL appear for them after release.

Configuration
REQ-032 Macro AES_ROUND_KEYONLY_EN SHALL control key-only support.
REQ-033 With AES_ROUND_KEYONLY_EN defined, mode 10 SHALL produce out_data = in_data ^ in_key, with the same latency as other modes.
REQ-034 Without AES_ROUND_KEYONLY_EN, mode 10 SHALL behave as a full round and no key-only logic SHALL exist.

Structure
REQ-035 Package aes_pkg SHALL hold:
  - the S-box table/function and xtime function;
  - the mode encoding constants;
  - the byte-index helper for column-major order.
REQ-036 Sub-module aes_mix_columns (combinational, 128-bit in/out) SHALL implement MixColumns; SubBytes and ShiftRows SHALL be functions from aes_pkg.

Verification
REQ-037 FIPS-197 C.1 round 1: mode 00, data 00102030405060708090a0b0c0d0e0f0, key d6aa74fdd2af72fadaa678f1d6ab76fe -> out_data 89d810e8855ace682d1843d8cb128fe4 after PIPE_STAGES cycles.
REQ-038 FIPS-197 C.1 round 10: mode 01, data bd6e7c3df2b5779e0b61216e8b10b689, key 13111d7fe3944a17f307a78b4d2b30c5 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-039 Back-to-back stream of 8 blocks, tags 0..7, with out_ready low on cycles 3-5 -> all 8 results out in tag order, each output held stable while stalled, no loss.
REQ-040 Key-only with macro defined: mode 10, data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> out_data 00102030405060708090a0b0c0d0e0f0; without the macro -> full-round result.
REQ-041 Assert rst mid-stream with 2 blocks in flight -> out_valid=0 immediately, in_ready=1, and no stale output after release.
REQ-042 Repeat REQ-037..REQ-041 for PIPE_STAGES = 1, 2, 3 -> latency exactly 1, 2, 3 cycles respectively.
